// File: rtl/rx_align_ctrl.sv
// ============================================================================
//  Module      : rx_align_ctrl
//  Description : Word-alignment / training controller for one 7:1 LVDS rx
//                channel (bitslip sweep, delay-tap sweep, lock tracking).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_align_ctrl #(
    parameter logic [6:0]  PATTERN  = 7'b1100011,
    parameter int unsigned SETTLE   = 4,
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned LOSS_CNT = 4,
    parameter int unsigned TAP_W    = 5,
    parameter int unsigned TAP_MAX  = 31
) (
    input  logic             rx_clk,
    input  logic             rx_reset_n,
    input  logic             enable,
    input  logic             word_valid,
    input  logic [6:0]       clk_word,
    output logic             bitslip,
    output logic             tap_rst,
    output logic             tap_inc,
    output logic [TAP_W-1:0] tap_value,
    output logic [2:0]       slip_count,
    output logic             locked,
    output logic             align_err,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TAP_RST  = 3'd1,
        S_SETTLE   = 3'd2,
        S_CHECK    = 3'd3,
        S_SLIP     = 3'd4,
        S_TAP_STEP = 3'd5,
        S_LOCKED   = 3'd6,
        S_ERROR    = 3'd7
    } state_t;

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [7:0]       LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [3:0]       LOSS_LAST   = 4'(LOSS_CNT - 1);
    localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(TAP_MAX);
    localparam logic [2:0]       SLIP_LAST   = 3'd6;

    state_t           state_q, state_d;
    logic [3:0]       settle_cnt_q, settle_cnt_d;
    logic [7:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       miss_cnt_q, miss_cnt_d;
    logic [TAP_W-1:0] tap_value_q, tap_value_d;
    logic [2:0]       slip_count_q, slip_count_d;
    logic             bitslip_q, bitslip_d;
    logic             tap_rst_q, tap_rst_d;
    logic             tap_inc_q, tap_inc_d;
    logic             locked_q, locked_d;
    logic             align_err_q, align_err_d;

    logic             word_match;
    assign word_match = (clk_word == PATTERN);

    // Pulses are raised on the edge that enters their one-cycle state, so the
    // pulse and the state code are visible in the same cycle.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        match_cnt_d  = match_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        tap_value_d  = tap_value_q;
        slip_count_d = slip_count_q;
        locked_d     = locked_q;
        align_err_d  = align_err_q;
        bitslip_d    = 1'b0;
        tap_rst_d    = 1'b0;
        tap_inc_d    = 1'b0;

        if (!enable) begin
            state_d      = S_IDLE;
            locked_d     = 1'b0;
            align_err_d  = 1'b0;
            settle_cnt_d = 4'd0;
            match_cnt_d  = 8'd0;
            miss_cnt_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d      = S_TAP_RST;
                    tap_rst_d    = 1'b1;
                    tap_value_d  = '0;
                    slip_count_d = 3'd0;
                end
                S_TAP_RST: begin
                    state_d      = S_SETTLE;
                    settle_cnt_d = 4'd0;
                end
                S_SETTLE: begin
                    if (word_valid) begin
                        if (settle_cnt_q == SETTLE_LAST) begin
                            state_d      = S_CHECK;
                            settle_cnt_d = 4'd0;
                            match_cnt_d  = 8'd0;
                            miss_cnt_d   = 4'd0;
                        end else begin
                            settle_cnt_d = settle_cnt_q + 4'd1;
                        end
                    end
                end
                S_CHECK: begin
                    if (word_valid) begin
                        if (word_match) begin
                            match_cnt_d = match_cnt_q + 8'd1;
                            if (match_cnt_q == LOCK_LAST) begin
                                state_d    = S_LOCKED;
                                locked_d   = 1'b1;
                                miss_cnt_d = 4'd0;
                            end
                        end else begin
                            match_cnt_d = 8'd0;
                            if (slip_count_q != SLIP_LAST) begin
                                state_d      = S_SLIP;
                                bitslip_d    = 1'b1;
                                slip_count_d = slip_count_q + 3'd1;
                            end else begin
                                state_d = S_TAP_STEP;
                                if (tap_value_q != TAP_LAST) begin
                                    tap_inc_d    = 1'b1;
                                    tap_value_d  = tap_value_q + 1'b1;
                                    slip_count_d = 3'd0;
                                end
                            end
                        end
                    end
                end
                S_SLIP: begin
                    state_d      = S_SETTLE;
                    settle_cnt_d = 4'd0;
                end
                S_TAP_STEP: begin
                    // No tap_inc on entry means the last tap was already tried.
                    if (tap_inc_q) begin
                        state_d      = S_SETTLE;
                        settle_cnt_d = 4'd0;
                    end else begin
                        state_d     = S_ERROR;
                        align_err_d = 1'b1;
                        locked_d    = 1'b0;
                    end
                end
                S_LOCKED: begin
                    if (word_valid) begin
                        if (word_match) begin
                            miss_cnt_d = 4'd0;
                        end else if (miss_cnt_q == LOSS_LAST) begin
                            state_d      = S_TAP_RST;
                            locked_d     = 1'b0;
                            tap_rst_d    = 1'b1;
                            tap_value_d  = '0;
                            slip_count_d = 3'd0;
                            miss_cnt_d   = 4'd0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 4'd1;
                        end
                    end
                end
                S_ERROR: begin
                    align_err_d = 1'b1;
                    locked_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge rx_clk or negedge rx_reset_n) begin
        if (!rx_reset_n) begin
            state_q      <= S_IDLE;
            settle_cnt_q <= 4'd0;
            match_cnt_q  <= 8'd0;
            miss_cnt_q   <= 4'd0;
            tap_value_q  <= '0;
            slip_count_q <= 3'd0;
            bitslip_q    <= 1'b0;
            tap_rst_q    <= 1'b0;
            tap_inc_q    <= 1'b0;
            locked_q     <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            match_cnt_q  <= match_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            tap_value_q  <= tap_value_d;
            slip_count_q <= slip_count_d;
            bitslip_q    <= bitslip_d;
            tap_rst_q    <= tap_rst_d;
            tap_inc_q    <= tap_inc_d;
            locked_q     <= locked_d;
            align_err_q  <= align_err_d;
        end
    end

    assign bitslip    = bitslip_q;
    assign tap_rst    = tap_rst_q;
    assign tap_inc    = tap_inc_q;
    assign tap_value  = tap_value_q;
    assign slip_count = slip_count_q;
    assign locked     = locked_q;
    assign align_err  = align_err_q;
    assign state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_align_ctrl.sv
// ============================================================================
//  Module      : tb_rx_align_ctrl
//  Description : Self-checking bench for rx_align_ctrl with a rotating-word
//                datapath model and phase-search reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rx_align_ctrl;

    localparam logic [6:0] PAT  = 7'b1100011;
    localparam int         SET  = 4;
    localparam int         LCK  = 16;
    localparam int         TMAX = 31;

    logic       rx_clk = 1'b0;
    logic       rx_reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       word_valid = 1'b0;
    logic [6:0] clk_word = 7'd0;
    logic       bitslip, tap_rst, tap_inc, locked, align_err;
    logic [4:0] tap_value;
    logic [2:0] slip_count, state;

    rx_align_ctrl dut (
        .rx_clk     (rx_clk),
        .rx_reset_n (rx_reset_n),
        .enable     (enable),
        .word_valid (word_valid),
        .clk_word   (clk_word),
        .bitslip    (bitslip),
        .tap_rst    (tap_rst),
        .tap_inc    (tap_inc),
        .tap_value  (tap_value),
        .slip_count (slip_count),
        .locked     (locked),
        .align_err  (align_err),
        .state      (state)
    );

    always #5 rx_clk = ~rx_clk;

    int         checks = 0;
    int         errors = 0;
    logic [6:0] dp_word = 7'd0;
    logic       ovr_en = 1'b0;
    logic [6:0] ovr_word = 7'd0;
    int         n_slip, n_rst, n_inc;
    int         vw = 1000;
    int         cyc = 0;
    int         last_pulse_cyc = 0;
    int         lock_vw = -1;
    int         lock_lat = -1;
    logic       locked_prev = 1'b0;
    int         valid_mode = 0;
    logic       alt = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] rotl(input logic [6:0] w);
        return {w[5:0], w[6]};
    endfunction

    function automatic logic [6:0] rotr_n(input logic [6:0] w, input int n);
        logic [6:0] r = w;
        for (int i = 0; i < n; i++) r = {r[0], r[6:1]};
        return r;
    endfunction

    // Number of datapath rotations needed before the word shows PAT; -1 if none.
    function automatic int ref_slips(input logic [6:0] base);
        logic [6:0] w = base;
        for (int k = 0; k < 7; k++) begin
            if (w == PAT) return k;
            w = rotl(w);
        end
        return -1;
    endfunction

    // One clock: observe the outputs settled since the last rising edge, react
    // as the datapath would, then drive the next word.
    task automatic step();
        int  np;
        bit  skip;
        @(negedge rx_clk);
        skip = 0;
        np = int'(bitslip) + int'(tap_rst) + int'(tap_inc);
        if (np != 0) begin
            chk("pulse_exclusive", np, 1);
            chk("pulse_gap_ge_settle", (vw >= SET), 1);
            vw = 0;
            skip = 1;
            last_pulse_cyc = cyc;
            if (bitslip) begin n_slip++; dp_word = rotl(dp_word); end
            if (tap_rst) n_rst++;
            if (tap_inc) n_inc++;
        end
        if (locked === 1'b1 && locked_prev !== 1'b1) begin
            lock_vw  = vw;
            lock_lat = cyc - last_pulse_cyc;
        end
        locked_prev = locked;
        alt = ~alt;
        case (valid_mode)
            0:       word_valid = 1'b1;
            1:       word_valid = alt;
            default: word_valid = ($urandom_range(0, 99) < 70);
        endcase
        clk_word = ovr_en ? ovr_word : dp_word;
        if (!skip && word_valid) vw++;
        cyc++;
    endtask

    task automatic run_until_done(input int budget);
        int i = 0;
        while (!(locked === 1'b1 || align_err === 1'b1) && i < budget) begin
            step();
            i++;
        end
        if (i >= budget) chk("timeout_lock_or_err", 0, 1);
    endtask

    task automatic start(input logic [6:0] base, input int budget);
        enable = 1'b0;
        step();
        step();
        n_slip = 0; n_rst = 0; n_inc = 0;
        lock_vw = -1; lock_lat = -1;
        vw = 1000;
        ovr_en = 1'b0;
        dp_word = base;
        enable = 1'b1;
        run_until_done(budget);
    endtask

    initial begin
        int k;
        int exp_slips;
        logic [6:0] base;

        // async reset state
        #2;
        chk("rst_state", state, 0);
        chk("rst_locked", locked, 0);
        chk("rst_pulses", {bitslip, tap_rst, tap_inc}, 0);
        chk("rst_tap", tap_value, 0);
        @(negedge rx_clk);
        rx_reset_n = 1'b1;

        // 1: already aligned
        start(PAT, 200);
        chk("t1_tap_rst_count", n_rst, 1);
        chk("t1_slips", n_slip, 0);
        chk("t1_tap_value", tap_value, 0);
        chk("t1_locked", locked, 1);
        chk("t1_state", state, 6);
        chk("t1_lock_valid_words", lock_vw, SET + LCK);

        // 2: rotated by 3
        base = rotr_n(PAT, 3);
        exp_slips = ref_slips(base);
        start(base, 500);
        chk("t2_slips", n_slip, exp_slips);
        chk("t2_slip_count", slip_count, exp_slips);
        chk("t2_tap_inc", n_inc, 0);
        chk("t2_locked", locked, 1);

        // randomized phase and valid gaps
        valid_mode = 2;
        for (int it = 0; it < 4; it++) begin
            k = $urandom_range(0, 6);
            base = rotr_n(PAT, k);
            exp_slips = ref_slips(base);
            start(base, 1000);
            chk("rnd_slips", n_slip, exp_slips);
            chk("rnd_slip_count", slip_count, exp_slips);
            chk("rnd_lock_valid_words", lock_vw, SET + LCK);
            chk("rnd_locked", locked, 1);
        end
        valid_mode = 0;

        // 3: never aligns
        start(7'h00, 5000);
        chk("t3_model_no_phase", ref_slips(7'h00) < 0, 1);
        chk("t3_slips", n_slip, 6 * (TMAX + 1));
        chk("t3_tap_inc", n_inc, TMAX);
        chk("t3_align_err", align_err, 1);
        chk("t3_state", state, 7);
        chk("t3_locked", locked, 0);
        chk("t3_tap_value", tap_value, TMAX);
        for (int i = 0; i < 10; i++) step();
        chk("t3_err_held", align_err, 1);
        chk("t3_no_pulse_in_err", n_slip + n_inc, 6 * (TMAX + 1) + TMAX);
        enable = 1'b0;
        step();
        chk("t3_idle_state", state, 0);
        chk("t3_err_cleared", align_err, 0);

        // 4: loss-of-lock tracking
        start(PAT, 200);
        chk("t4_locked", locked, 1);
        n_rst = 0;
        for (int r = 0; r < 5; r++) begin
            k = $urandom_range(0, 3);
            for (int i = 0; i < k; i++) begin
                ovr_en = 1'b1;
                ovr_word = PAT ^ 7'($urandom_range(1, 127));
                step();
            end
            ovr_en = 1'b0;
            step();
        end
        step();
        chk("t4_hold_lock", locked, 1);
        chk("t4_hold_state", state, 6);
        chk("t4_no_retrain", n_rst, 0);
        for (int i = 0; i < 4; i++) begin
            ovr_en = 1'b1;
            ovr_word = PAT ^ 7'($urandom_range(1, 127));
            step();
        end
        ovr_en = 1'b0;
        step();
        chk("t4_lock_dropped", locked, 0);
        chk("t4_retrain_tap_rst", n_rst, 1);
        chk("t4_retrain_state", state, 1);
        lock_vw = -1;
        run_until_done(200);
        chk("t4_relocked", locked, 1);
        chk("t4_relock_valid_words", lock_vw, SET + LCK);

        // 5: valid every other cycle
        valid_mode = 1;
        base = rotr_n(PAT, 2);
        start(base, 2000);
        chk("t5_slips", n_slip, ref_slips(base));
        chk("t5_tap_rst_count", n_rst, 1);
        chk("t5_lock_valid_words", lock_vw, SET + LCK);
        chk("t5_lock_cycles_doubled", lock_lat >= 2 * (SET + LCK) - 1, 1);
        valid_mode = 0;

        // 6a: async reset in SLIP
        enable = 1'b0;
        step();
        dp_word = rotr_n(PAT, 3);
        vw = 1000;
        enable = 1'b1;
        k = 0;
        while (bitslip !== 1'b1 && k < 200) begin step(); k++; end
        chk("t6_reached_slip", state, 4);
        rx_reset_n = 1'b0;
        #1;
        chk("t6_async_state", state, 0);
        chk("t6_async_outputs", {bitslip, tap_rst, tap_inc, locked, align_err}, 0);
        chk("t6_async_counts", {tap_value, slip_count}, 0);
        @(negedge rx_clk);
        rx_reset_n = 1'b1;
        vw = 1000;
        locked_prev = 1'b0;

        // 6b: disable during CHECK
        k = 0;
        while (state !== 3'd3 && k < 200) begin step(); k++; end
        chk("t6_reached_check", state, 3);
        enable = 1'b0;
        step();
        chk("t6_disable_state", state, 0);
        chk("t6_disable_outputs", {bitslip, tap_rst, tap_inc, locked, align_err}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
